// File: rtl/vga_text_pkg.sv
// vga_text_pkg: shared constants for the 80x30 text-mode renderer.
// Screen geometry, glyph size, pipeline latency and the field layout
// of the 16-bit character/attribute word live here.
package vga_text_pkg;

   // Text screen geometry
   localparam int COLS    = 80;
   localparam int ROWS    = 30;

   // Glyph cell size in pixels
   localparam int FONT_W  = 8;
   localparam int FONT_H  = 16;

   // Input-to-output delay in pixel clocks, identical for every signal
   localparam int LATENCY = 4;

   // Character/attribute word layout: [7:0] code, [10:8] fg, [14:12] bg
   localparam int CODE_LSB = 0;
   localparam int CODE_W   = 8;
   localparam int FG_LSB   = 8;
   localparam int BG_LSB   = 12;
   localparam int COLOUR_W = 3;

   // First glyph row covered by the underline-style cursor (rows 14-15)
   localparam int CURSOR_ROW_FIRST = 14;

   // 1-bit-per-channel colour, {R,G,B}
   typedef logic [COLOUR_W-1:0] colour_t;

endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line: fixed-depth shift register with a per-bit reset value.
// Used to carry beam side-band bits (sync, visibility, glyph-cell
// offsets, cursor hit) alongside the memory read pipeline.
module vga_delay_line #(
   parameter int               WIDTH   = 1,
   parameter int               DEPTH   = 1,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             CLK_PIXEL,
   input  logic             RESET_N,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] stage_q [DEPTH];

   // Shift din through DEPTH stages; reset loads every stage with RST_VAL
   always_ff @(posedge CLK_PIXEL or negedge RESET_N) begin
      if (!RESET_N) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= RST_VAL;
         end
      end else begin
         stage_q[0] <= din;
         for (int i = 1; i < DEPTH; i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end
   end

   assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_text_render.sv
// vga_text_render: turns the VGA beam position into an 80x30 text-mode
// picture of 8x16 glyphs, reading an external character/attribute RAM
// and font ROM (both synchronous read, 1-cycle latency).
//
// Pipeline (edge numbers counted from the edge that samples the inputs):
//   edge 1: CHAR_ADDR registered, side-band bits enter the delay lines
//   edge 2: RAM presents CHAR_DATA, FONT_ADDR formed combinationally
//   edge 3: ROM presents FONT_DATA, fg/bg attributes registered
//   edge 4: pixel selected, colour and syncs registered to the outputs
// The pipeline is free-running: every cycle carries a beam position,
// there is no valid/ready handshake and nothing ever stalls.
//
// Optional build macro CURSOR_EN adds a blinking underline cursor at
// CURSOR_COL/CURSOR_ROW (fg/bg swapped on glyph rows 14-15).
module vga_text_render
   import vga_text_pkg::*;
#(
   parameter int COLS   = vga_text_pkg::COLS,
   parameter int ROWS   = vga_text_pkg::ROWS,
   parameter int ADDR_W = 12
) (
   input  logic              CLK_PIXEL,
   input  logic              RESET_N,
   input  logic [10:0]       SCREEN_X,
   input  logic [10:0]       SCREEN_Y,
   input  logic              ON_SCREEN,
   input  logic              HS_IN,
   input  logic              VS_IN,
   output logic [ADDR_W-1:0] CHAR_ADDR,
   input  logic [15:0]       CHAR_DATA,
   output logic [11:0]       FONT_ADDR,
   input  logic [7:0]        FONT_DATA,
   input  logic [6:0]        CURSOR_COL,
   input  logic [4:0]        CURSOR_ROW,
   output logic              R,
   output logic              G,
   output logic              B,
   output logic              HS_OUT,
   output logic              VS_OUT
);

   localparam int X_LO_W = $clog2(FONT_W);
   localparam int Y_LO_W = $clog2(FONT_H);

   // Side-band bits are needed at edge 4 (x offset, syncs, visibility)
   // while the glyph row offset is needed one stage earlier for FONT_ADDR.
   localparam int SIDE_DEPTH = LATENCY - 1;
   localparam int Y_DEPTH    = LATENCY - 2;

   // Bit positions inside the side-band delay word
   localparam int X_LSB   = 0;
   localparam int VS_BIT  = X_LO_W;
   localparam int HS_BIT  = X_LO_W + 1;
   localparam int ON_BIT  = X_LO_W + 2;
`ifdef CURSOR_EN
   localparam int HIT_BIT = X_LO_W + 3;
   localparam int SIDE_W  = X_LO_W + 4;
`else
   localparam int SIDE_W  = X_LO_W + 3;
`endif

   // Syncs idle high, everything else clears to zero
   localparam logic [SIDE_W-1:0] SIDE_RST =
      SIDE_W'((1 << VS_BIT) | (1 << HS_BIT));

   // Reject a configuration whose address width cannot hold every cell
   if (COLS * ROWS > (1 << ADDR_W)) begin : g_addr_w_check
      $error("vga_text_render: ADDR_W too narrow for COLS*ROWS");
   end

   // ------------------------------------------------------------------
   // Character address
   // ------------------------------------------------------------------
   logic [ADDR_W-1:0] row_base;
   logic [ADDR_W-1:0] cell_addr;

   assign row_base  = ADDR_W'(SCREEN_Y[8:4]) * ADDR_W'(COLS);
   assign cell_addr = row_base + ADDR_W'(SCREEN_X[9:3]);

   // Issue a new cell address only in the visible region; hold otherwise
   always_ff @(posedge CLK_PIXEL or negedge RESET_N) begin
      if (!RESET_N) begin
         CHAR_ADDR <= '0;
      end else if (ON_SCREEN) begin
         CHAR_ADDR <= cell_addr;
      end
   end

   // ------------------------------------------------------------------
   // Optional blinking cursor
   // ------------------------------------------------------------------
`ifdef CURSOR_EN
   logic       vs_prev;
   logic [5:0] frame_cnt;
   logic       cursor_hit;
   logic       blink_on;

   assign cursor_hit = ON_SCREEN
                    && (SCREEN_X[9:3] == CURSOR_COL)
                    && (SCREEN_Y[8:4] == CURSOR_ROW)
                    && (SCREEN_Y[3:0] >= 4'(CURSOR_ROW_FIRST));

   // Count frames on VS_IN falling edges to drive the 32-on/32-off blink
   always_ff @(posedge CLK_PIXEL or negedge RESET_N) begin
      if (!RESET_N) begin
         vs_prev   <= 1'b1;
         frame_cnt <= '0;
      end else begin
         vs_prev <= VS_IN;
         if (vs_prev && !VS_IN) begin
            frame_cnt <= frame_cnt + 6'd1;
         end
      end
   end

   assign blink_on = ~frame_cnt[5];
`endif

   // ------------------------------------------------------------------
   // Side-band delay lines
   // ------------------------------------------------------------------
   logic [SIDE_W-1:0] side_in;
   logic [SIDE_W-1:0] side_d3;
   logic [Y_LO_W-1:0] y_d2;

`ifdef CURSOR_EN
   assign side_in = {cursor_hit, ON_SCREEN, HS_IN, VS_IN, SCREEN_X[X_LO_W-1:0]};
`else
   assign side_in = {ON_SCREEN, HS_IN, VS_IN, SCREEN_X[X_LO_W-1:0]};
`endif

   vga_delay_line #(
      .WIDTH   (SIDE_W),
      .DEPTH   (SIDE_DEPTH),
      .RST_VAL (SIDE_RST)
   ) u_side_dly (
      .CLK_PIXEL (CLK_PIXEL),
      .RESET_N   (RESET_N),
      .din       (side_in),
      .dout      (side_d3)
   );

   vga_delay_line #(
      .WIDTH   (Y_LO_W),
      .DEPTH   (Y_DEPTH),
      .RST_VAL ('0)
   ) u_y_dly (
      .CLK_PIXEL (CLK_PIXEL),
      .RESET_N   (RESET_N),
      .din       (SCREEN_Y[Y_LO_W-1:0]),
      .dout      (y_d2)
   );

   logic [X_LO_W-1:0] x_d3;
   logic              on_d3;
   logic              hs_d3;
   logic              vs_d3;

   assign x_d3  = side_d3[X_LSB +: X_LO_W];
   assign vs_d3 = side_d3[VS_BIT];
   assign hs_d3 = side_d3[HS_BIT];
   assign on_d3 = side_d3[ON_BIT];

   // ------------------------------------------------------------------
   // Font lookup and attribute capture
   // ------------------------------------------------------------------
   assign FONT_ADDR = {CHAR_DATA[CODE_LSB +: CODE_W], y_d2};

   colour_t fg_q;
   colour_t bg_q;

   // Hold the cell attributes so they line up with FONT_DATA
   always_ff @(posedge CLK_PIXEL or negedge RESET_N) begin
      if (!RESET_N) begin
         fg_q <= '0;
         bg_q <= '0;
      end else begin
         fg_q <= CHAR_DATA[FG_LSB +: COLOUR_W];
         bg_q <= CHAR_DATA[BG_LSB +: COLOUR_W];
      end
   end

   // ------------------------------------------------------------------
   // Pixel select and colour
   // ------------------------------------------------------------------
   logic    pix;
   colour_t fg_eff;
   colour_t bg_eff;
   colour_t colour;

   // Glyph bit 7 is the leftmost pixel of the cell
   assign pix = FONT_DATA[X_LO_W'(FONT_W - 1) - x_d3];

   // Effective fg/bg, swapped under a visible cursor
   always_comb begin
      fg_eff = fg_q;
      bg_eff = bg_q;
`ifdef CURSOR_EN
      if (side_d3[HIT_BIT] && blink_on) begin
         fg_eff = bg_q;
         bg_eff = fg_q;
      end
`endif
   end

   assign colour = on_d3 ? (pix ? fg_eff : bg_eff) : colour_t'(0);

   // Output register: colour plus syncs, all with the same latency
   always_ff @(posedge CLK_PIXEL or negedge RESET_N) begin
      if (!RESET_N) begin
         R      <= 1'b0;
         G      <= 1'b0;
         B      <= 1'b0;
         HS_OUT <= 1'b1;
         VS_OUT <= 1'b1;
      end else begin
         R      <= colour[2];
         G      <= colour[1];
         B      <= colour[0];
         HS_OUT <= hs_d3;
         VS_OUT <= vs_d3;
      end
   end

   // Input bits this block has no use for
   logic unused_bits;
`ifdef CURSOR_EN
   assign unused_bits = ^{SCREEN_X[10], SCREEN_Y[10:9], CHAR_DATA[15], CHAR_DATA[11]};
`else
   assign unused_bits = ^{SCREEN_X[10], SCREEN_Y[10:9], CHAR_DATA[15], CHAR_DATA[11],
                          CURSOR_COL, CURSOR_ROW};
`endif

endmodule

// File: doc/vga_text_render.md
Name: vga_text_render

Overview:
- Downstream consumer of the VGA timing generator's outputs: SCREEN_X, SCREEN_Y, ON_SCREEN, Hs, Vs.
- Converts the beam position into an 80x30 text-mode picture using 8x16 glyphs.
- Character/attribute RAM and font ROM are external synchronous-read memories with 1-cycle read latency. This block drives their addresses and consumes their data.
- Output is 1-bit R/G/B plus syncs, all delayed to align with pixel data.

Parameters:
- COLS, 80, text columns per row.
- ROWS, 30, text rows per screen.
- ADDR_W, 12, character RAM address width (must hold COLS*ROWS-1 = 2399).

Ports:
- CLK_PIXEL  in  1  pixel clock, 25.175 MHz.
- RESET_N  in  1  asynchronous, active-low reset.
- SCREEN_X  in  11  beam column from the timing generator.
- SCREEN_Y  in  11  beam row from the timing generator.
- ON_SCREEN  in  1  high in the visible 640x480 region.
- HS_IN  in  1  horizontal sync, active low.
- VS_IN  in  1  vertical sync, active low.
- CHAR_ADDR  out  ADDR_W  character RAM read address.
- CHAR_DATA  in  16  RAM word: [7:0] glyph code, [10:8] fg colour, [14:12] bg colour, [11] and [15] unused.
- FONT_ADDR  out  12  font ROM address.
- FONT_DATA  in  8  glyph row; bit 7 is the leftmost pixel.
- CURSOR_COL  in  7  cursor column (used only with CURSOR_EN).
- CURSOR_ROW  in  5  cursor row (used only with CURSOR_EN).
- R, G, B  out  1 each  pixel colour.
- HS_OUT, VS_OUT  out  1 each  delayed syncs.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - CHAR_ADDR=0, R=G=B=0, HS_OUT=VS_OUT=1.
  - All pipeline registers cleared; delayed ON_SCREEN=0, delayed syncs=1.
- Edge 1:
  - If ON_SCREEN=1: CHAR_ADDR <= SCREEN_Y[8:4]*COLS + SCREEN_X[9:3], computed at ADDR_W bits with no overflow for in-range inputs.
  - If ON_SCREEN=0: CHAR_ADDR holds its value, so no out-of-range address is ever issued.
  - Same edge: x[2:0], y[3:0], ON_SCREEN, HS_IN, VS_IN enter the delay pipeline.
- Edge 2: external RAM presents CHAR_DATA. FONT_ADDR = {CHAR_DATA[7:0], y_d2[3:0]}, combinational.
- Edge 3: external ROM presents FONT_DATA. Attribute bits CHAR_DATA[14:8] are registered alongside.
- Edge 4 (output register):
  - pix = FONT_DATA[7 - x_d3].
  - colour = pix ? fg : bg; R=colour[2], G=colour[1], B=colour[0].
  - If ON_SCREEN_d3=0, force R=G=B=0.
  - HS_OUT=HS_IN_d3, VS_OUT=VS_IN_d3.
- Total latency is exactly 4 CLK_PIXEL cycles from input to R/G/B/HS_OUT/VS_OUT, for every signal.
- Pipeline is free-running: no stalls, no handshake.
- Wrap-around: X/Y wrapping from 799/524 back to 0 needs no special handling, because the position is re-evaluated every cycle.
- Reset mid-frame: outputs go to reset values immediately. After release, the first valid pixel appears 4 cycles after the first ON_SCREEN=1 input.

Optional Feature:
- Macro CURSOR_EN.
- When defined:
  - A 6-bit frame counter increments on each VS_IN falling edge, detected against a registered previous value.
  - Blink phase is visible when counter[5]=0, giving 32 frames on and 32 off.
  - Cursor hit = ON_SCREEN && SCREEN_X[9:3]==CURSOR_COL && SCREEN_Y[8:4]==CURSOR_ROW && SCREEN_Y[3:1]==3'b111 (glyph rows 14-15). The hit is registered at edge 1 and pipelined.
  - At edge 4, when hit && visible, fg and bg are swapped.
  - Counter resets to 0.
- When undefined: no counter and no cursor logic; CURSOR_COL and CURSOR_ROW are ignored.

Decomposition:
- Package vga_text_pkg holds:
  - COLS, ROWS, FONT_W=8, FONT_H=16, LATENCY=4.
  - Attribute field positions (CODE_LSB=0, FG_LSB=8, BG_LSB=12) and the CURSOR_ROW_FIRST=14 constant.
- One sub-module, vga_delay_line: parameterised width/depth shift register with per-bit reset values. It carries ON_SCREEN, HS, VS, x/y low bits and the cursor hit through the pipeline.

Test Plan:
- Reset: hold RESET_N=0 mid-line -> HS_OUT=VS_OUT=1, R=G=B=0, CHAR_ADDR=0.
- Addressing: ON_SCREEN=1, SCREEN_X=17, SCREEN_Y=35 -> CHAR_ADDR=162 after 1 edge.
- Addressing boundaries: X=639, Y=479 -> CHAR_ADDR=2399. Then ON_SCREEN=0, X=700 -> CHAR_ADDR stays 2399.
- Pixel path: CHAR_DATA=0x7141, FONT_DATA=0x80.
  - x%8=0 -> RGB=001 four cycles later.
  - x%8=1 -> RGB=111.
  - FONT_DATA must be addressed at 0x41<<4 | y[3:0].
- Sync alignment: HS_IN falls at cycle t -> HS_OUT falls at t+4. With ON_SCREEN=0 and FONT_DATA=0xFF -> RGB=000.
- CURSOR_EN build: CURSOR_COL=5, CURSOR_ROW=3, counter=0 -> colours inverted at X=40..47, Y=62..63 only. After 32 VS falling edges -> no inversion. After 64 -> inversion returns.
